ahb_lite_burst_master: RTL

- Parametrised AHB-Lite master. Accepts one command at a time on the cmd interface: req, wr, byte_cnt, start_addr, with req_ack and done back.
- Turns each command into a pipelined INCR burst of word transfers.
- Write data is pulled from a first-word-fall-through (FWFT) source. Read data is pushed out as a valid-qualified stream.
- Sits between the DMA/command engine and the AHB interconnect. Successor to the single-transfer command master: adds burst pipelining, wait-state handling, 1KB-boundary splitting and error reporting.

---
 rtl/ahb_lite_burst_master.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_burst_master.sv
// ahb_lite_burst_master: AHB-Lite master that turns one command (read/write,
// byte count, start address) into a pipelined INCR burst of word transfers.
// Write data comes from an FWFT source. Read data leaves as a valid-qualified stream.
// A 1KB boundary restarts the burst with NONSEQ.
// Optional build macro AHB_ERR_ABORT_EN: an ERROR response cancels the rest of
// the burst. Without it, the burst runs to the end and the cancelled transfer
// is reissued as NONSEQ.
//
// Handshakes:
//   cmd_req is held by the requester until cmd_req_ack; the ack is a
//   single-cycle pulse, only in IDLE.
//   wd_pop pops the head word in the same cycle that it is copied into HWDATA.
//   rd_valid qualifies rd_data for exactly one cycle per good read beat.
//   cmd_done is a single-cycle pulse, and cmd_err is valid only alongside it.
module ahb_lite_burst_master #(
  parameter int ADDRW     = 32,
  parameter int DATAW     = 32,
  parameter int BYTE_CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_req,
  input  logic                 cmd_wr,
  input  logic [BYTE_CNTW-1:0] cmd_byte_cnt,
  input  logic [ADDRW-1:0]     cmd_start_addr,
  output logic                 cmd_req_ack,
  output logic                 cmd_done,
  output logic                 cmd_err,
  input  logic [DATAW-1:0]     wd_data,
  output logic                 wd_pop,
  output logic [DATAW-1:0]     rd_data,
  output logic                 rd_valid,
  output logic [ADDRW-1:0]     HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [DATAW-1:0]     HWDATA,
  input  logic [DATAW-1:0]     HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  localparam int BEAT_BYTES = DATAW / 8;
  localparam int BEAT_SHIFT = (DATAW == 64) ? 3 : 2;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDRW-1:0]     haddr_q, haddr_d;
  logic [1:0]           htrans_q, htrans_d;
  logic                 hwrite_q, hwrite_d;
  logic [DATAW-1:0]     hwdata_q, hwdata_d;
  logic [DATAW-1:0]     rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 cmd_done_q, cmd_done_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 err_q, err_d;        // sticky: an ERROR was seen in this command
  logic [BYTE_CNTW-1:0] rem_q, rem_d;        // address phases still to be accepted
  logic [BYTE_CNTW-1:0] beats;
  logic [ADDRW-1:0]     addr_next;
  logic                 addr_acc;
  logic                 take_addr;

  assign beats     = cmd_byte_cnt >> BEAT_SHIFT;
  assign addr_next = haddr_q + ADDRW'(BEAT_BYTES);
  // A driven transfer is accepted by the slave whenever HREADY is high.
  assign addr_acc  = HREADY && (htrans_q != TR_IDLE);

  // Next-state and bus-control logic for the command/burst sequencer.
  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    cmd_done_d = 1'b0;
    cmd_err_d  = 1'b0;
    err_d      = err_q;
    rem_d      = rem_q;
    take_addr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_req) begin
          err_d = 1'b0;
          if (beats == '0) begin
            state_d    = S_DONE;
            cmd_done_d = 1'b1;
          end else begin
            state_d  = S_ADDR;
            haddr_d  = cmd_start_addr;
            hwrite_d = cmd_wr;
            htrans_d = TR_NONSEQ;
            rem_d    = beats;
          end
        end
      end
      S_ADDR: take_addr = addr_acc;
      S_BURST, S_LAST: begin
        if (HRESP && !HREADY) begin
          // First ERROR cycle: the held address phase is cancelled or reissued.
          err_d   = 1'b1;
          state_d = S_ERR;
`ifdef AHB_ERR_ABORT_EN
          htrans_d = TR_IDLE;
`else
          htrans_d = (htrans_q != TR_IDLE) ? TR_NONSEQ : TR_IDLE;
`endif
        end else if (HREADY) begin
          if (HRESP) begin
            err_d = 1'b1;
          end else if (!hwrite_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
          end
          if (state_q == S_LAST) begin
            state_d    = S_DONE;
            cmd_done_d = 1'b1;
            cmd_err_d  = err_q | HRESP;
          end else begin
            take_addr = addr_acc;
          end
        end
      end
      S_ERR: begin
        if (HREADY) begin
`ifdef AHB_ERR_ABORT_EN
          state_d    = S_DONE;
          cmd_done_d = 1'b1;
          cmd_err_d  = 1'b1;
`else
          if (addr_acc) begin
            take_addr = 1'b1;
          end else begin
            state_d    = S_DONE;
            cmd_done_d = 1'b1;
            cmd_err_d  = 1'b1;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An accepted address phase advances the burst by one beat.
    if (take_addr) begin
      haddr_d = addr_next;
      rem_d   = rem_q - BYTE_CNTW'(1);
      if (hwrite_q) hwdata_d = wd_data;
      if (rem_q == BYTE_CNTW'(1)) begin
        htrans_d = TR_IDLE;
        state_d  = S_LAST;
      end else begin
        htrans_d = (addr_next[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
        state_d  = S_BURST;
      end
    end
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      htrans_q   <= TR_IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      cmd_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      err_q      <= 1'b0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      cmd_done_q <= cmd_done_d;
      cmd_err_q  <= cmd_err_d;
      err_q      <= err_d;
      rem_q      <= rem_d;
    end
  end

  assign cmd_req_ack = rst_n && cmd_req && (state_q == S_IDLE);
  assign wd_pop      = take_addr && hwrite_q;
  assign cmd_done    = cmd_done_q;
  assign cmd_err     = cmd_err_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = 3'(BEAT_SHIFT);
  assign HBURST      = 3'b001;
  assign HWDATA      = hwdata_q;

endmodule
